// File: rtl/fetch_prefetch.sv
// Fetch stage with an instruction prefetch queue: issues PCs ahead of decode, pairs returned
// words with their PCs and splits each instruction into scalar/vector decode slots.
module fetch_prefetch #(
  parameter int unsigned    N        = 24,
  parameter int unsigned    DEPTH    = 4,
  parameter int unsigned    PC_STEP  = 1,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int unsigned    VEC_BIT  = N - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] ResultW,
  input  logic [N-1:0] ALUResultE,
  input  logic         PCSrcW,
  input  logic         BranchTakenE,
  input  logic         StallF,
  input  logic         StallD,
  input  logic         FlushD,
  input  logic [N-1:0] imem_data,
  input  logic         imem_valid,
  output logic [N-1:0] PCF,
  output logic         imem_req,
  output logic [N-1:0] InstrD,
  output logic [N-1:0] InstrD_vector,
  output logic [N-1:0] PCPlus8D,
  output logic         ValidD
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam logic [N-1:0]  Step     = N'(PC_STEP);
  localparam cnt_t          DepthCnt = cnt_t'(DEPTH);
  localparam logic [CntW:0] DepthOcc = (CntW + 1)'(DEPTH);

  logic [N-1:0] pcf_q, pcf_d;
  cnt_t         inflight_q, inflight_d;
  cnt_t         drop_q, drop_d;
  cnt_t         count_q, count_d;
  ptr_t         wptr_q, wptr_d, rptr_q, rptr_d;
  ptr_t         sh_wptr_q, sh_wptr_d, sh_rptr_q, sh_rptr_d;

  logic [N-1:0] fifo_pc    [DEPTH];
  logic [N-1:0] fifo_instr [DEPTH];
  logic [N-1:0] sh_pc      [DEPTH];

  logic [N-1:0] instr_q, instr_d;
  logic [N-1:0] instr_vec_q, instr_vec_d;
  logic [N-1:0] pc_plus_q, pc_plus_d;
  logic         valid_q, valid_d;

  logic          redirect;
  logic [N-1:0]  redirect_pc;
  logic [CntW:0] occupancy;
  logic          resp_dec, accept, push, pop;
  logic [N-1:0]  head_pc, head_instr;

  always_comb begin
    redirect    = BranchTakenE || PCSrcW;
    redirect_pc = BranchTakenE ? ALUResultE : ResultW;
    // Credit counts words still in memory plus words buffered; no credit for a same-cycle pop.
    occupancy   = {1'b0, inflight_q} + {1'b0, count_q};
    imem_req    = !rst && !StallF && !redirect && (occupancy < DepthOcc);
    resp_dec    = imem_valid && (inflight_q != '0);
    accept      = imem_valid && (drop_q == '0) && !redirect;
    push        = accept && (count_q != DepthCnt);
    pop         = !FlushD && !StallD && !redirect && (count_q != '0);
    head_pc     = fifo_pc[rptr_q];
    head_instr  = fifo_instr[rptr_q];
  end

  always_comb begin
    pcf_d      = pcf_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    sh_wptr_d  = sh_wptr_q;
    sh_rptr_d  = sh_rptr_q;
    if (redirect) begin
      // Every response still owed by memory belongs to the old path.
      pcf_d      = redirect_pc;
      inflight_d = inflight_q - cnt_t'(resp_dec);
      drop_d     = inflight_q - cnt_t'(resp_dec);
      count_d    = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      sh_wptr_d  = '0;
      sh_rptr_d  = '0;
    end else begin
      if (imem_req) begin
        pcf_d     = pcf_q + Step;
        sh_wptr_d = sh_wptr_q + ptr_t'(1);
      end
      inflight_d = inflight_q + cnt_t'(imem_req) - cnt_t'(resp_dec);
      if (imem_valid && (drop_q != '0)) begin
        drop_d = drop_q - cnt_t'(1);
      end
      if (accept) begin
        sh_rptr_d = sh_rptr_q + ptr_t'(1);
      end
      if (push) begin
        wptr_d = wptr_q + ptr_t'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + ptr_t'(1);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_comb begin
    instr_d     = instr_q;
    instr_vec_d = instr_vec_q;
    pc_plus_d   = pc_plus_q;
    valid_d     = valid_q;
    if (FlushD) begin
      instr_d     = '0;
      instr_vec_d = '0;
      pc_plus_d   = '0;
      valid_d     = 1'b0;
    end else if (StallD) begin
      valid_d = valid_q;
    end else if (pop) begin
      valid_d   = 1'b1;
      pc_plus_d = head_pc + Step;
      if (head_instr[VEC_BIT]) begin
        instr_d     = '0;
        instr_vec_d = head_instr;
      end else begin
        instr_d     = head_instr;
        instr_vec_d = '0;
      end
    end else begin
      instr_d     = '0;
      instr_vec_d = '0;
      valid_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcf_q       <= RESET_PC;
      inflight_q  <= '0;
      drop_q      <= '0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      sh_wptr_q   <= '0;
      sh_rptr_q   <= '0;
      instr_q     <= '0;
      instr_vec_q <= '0;
      pc_plus_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      pcf_q       <= pcf_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      sh_wptr_q   <= sh_wptr_d;
      sh_rptr_q   <= sh_rptr_d;
      instr_q     <= instr_d;
      instr_vec_q <= instr_vec_d;
      pc_plus_q   <= pc_plus_d;
      valid_q     <= valid_d;
    end
  end

  // Storage arrays carry no reset; pointers and counts define which entries are live.
  always_ff @(posedge clk) begin
    if (imem_req) begin
      sh_pc[sh_wptr_q] <= pcf_q;
    end
    if (push) begin
      fifo_pc[wptr_q]    <= sh_pc[sh_rptr_q];
      fifo_instr[wptr_q] <= imem_data;
    end
  end

  assign PCF           = pcf_q;
  assign InstrD        = instr_q;
  assign InstrD_vector = instr_vec_q;
  assign PCPlus8D      = pc_plus_q;
  assign ValidD        = valid_q;

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parameterised pipeline fetch stage with an instruction prefetch queue. It decouples instruction-memory latency from the decode stage by issuing PC requests ahead of consumption and buffering returned words, together with their PCs, in a DEPTH-entry FIFO. It sits between the PC-redirect sources (execute and writeback) and the fetch/decode pipeline register. It also splits each instruction into scalar and vector datapath slots.

## Interface
- N, 24, instruction/address width
- DEPTH, 4, prefetch FIFO entries and maximum requests in flight (power of 2, ≥2)
- PC_STEP, 1, PC increment per instruction (word-addressed instruction memory)
- RESET_PC, 0, PC value after reset
- VEC_BIT, N-1, instruction bit that selects the vector datapath
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ResultW  in  N  writeback redirect target
- ALUResultE  in  N  execute (branch) redirect target
- PCSrcW  in  1  redirect to ResultW
- BranchTakenE  in  1  redirect to ALUResultE
- StallF  in  1  suppress new memory requests
- StallD  in  1  hold the decode register
- FlushD  in  1  clear the decode register
- imem_data  in  N  memory read data
- imem_valid  in  1  imem_data valid; responses return in order, latency ≥1
- PCF  out  N  request address (next PC to issue)
- imem_req  out  1  request strobe for PCF; memory accepts every strobe
- InstrD  out  N  scalar instruction to decode
- InstrD_vector  out  N  vector instruction to decode
- PCPlus8D  out  N  PC of decode instruction + PC_STEP
- ValidD  out  1  decode register holds a real instruction

## Operation
- State: PCF register; inflight counter (0..DEPTH); drop counter (0..inflight); FIFO of {pc, instr} with count; decode register {InstrD, InstrD_vector, PCPlus8D, ValidD}.
- Issue: imem_req = !rst && !StallF && !redirect && (inflight + count) < DEPTH. Both values are the current-cycle values (conservative credit, no same-cycle-pop credit). When issuing, PCF <= PCF + PC_STEP, modulo 2^N.
- Each issue also records the issued PC into an in-order PC shadow queue (DEPTH entries) so responses can be paired with their PC.
- Response: when imem_valid, inflight decrements (net with a same-cycle issue). If drop > 0, drop decrements and the word is discarded. Otherwise {pc, imem_data} is pushed to the FIFO. The FIFO cannot overflow by the credit rule.
- Redirect = BranchTakenE || PCSrcW, with BranchTakenE taking priority.
  - PCF <= ALUResultE or ResultW.
  - FIFO and PC shadow queue are cleared.
  - drop <= inflight − imem_valid, so every older response is discarded.
  - No issue occurs in the redirect cycle.
  - Redirect overrides StallF.
- Decode register, in priority order:
  - FlushD: all fields 0.
  - Else StallD: hold.
  - Else FIFO non-empty and no redirect: pop the head and set ValidD=1. If instr[VEC_BIT]=1, InstrD_vector=instr and InstrD=0; otherwise InstrD=instr and InstrD_vector=0. PCPlus8D = pc + PC_STEP.
  - Else: ValidD=0, InstrD=0, InstrD_vector=0, PCPlus8D holds.
- Reset mid-operation: all counters, the FIFO and the drop count clear. Responses returned after reset for pre-reset requests are ignored only if the memory is also reset; the block treats imem_valid after reset as new data.

## Timing
- Reset values:
  - PCF = RESET_PC, imem_req = 0.
  - InstrD = InstrD_vector = PCPlus8D = 0, ValidD = 0.
  - inflight = drop = count = 0.
- First imem_req is high in the first cycle with rst low.
- Request in cycle t with memory latency L: FIFO write at end of t+L, ValidD high in cycle t+L+2. Minimum request-to-decode latency is L+2.
- Sustained throughput is one instruction per cycle when L+2 ≤ DEPTH.
- Redirect in cycle r: imem_req=1 with the target PCF in cycle r+1. The first target instruction reaches decode at r+1+L+2 at the earliest.
- FIFO full with StallD: issue stops once inflight+count = DEPTH and resumes the cycle after a pop.
- FlushD and StallD together: flush wins. A redirect in the same cycle as a FIFO pop suppresses the pop.

## Test plan
- Reset, L=1, no stalls: PCF sequence 0,1,2,…; ValidD first high in cycle 3. InstrD matches memory word k, with PCPlus8D = k+1.
- StallD held for 10 cycles with DEPTH=4, L=2: imem_req drops after 4 outstanding/buffered entries. After release, 4 instructions pop back-to-back, in order, with none lost or duplicated.
- BranchTakenE with ALUResultE=0x40 while 3 responses are in flight: those 3 are discarded. The next ValidD carries the word at 0x40 with PCPlus8D=0x41.
- BranchTakenE and PCSrcW in the same cycle with ALUResultE=0x10 and ResultW=0x20: PCF=0x10 next cycle.
- Word 0x800001 with VEC_BIT=23 → InstrD_vector=0x800001 and InstrD=0. Word 0x000005 → InstrD=0x000005 and InstrD_vector=0.
- Assert rst during streaming, with StallF, FlushD and StallD combinations around it: every output returns to its reset value next cycle, and PCF restarts at RESET_PC.
